// File: rtl/dcache_pkg.sv
// Shared definitions for the 2-way data cache.
//   state_e      : controller state encoding
//   calc_offs_w  : byte-offset width for a line of line_w bits
//   calc_tag_w   : tag width left over after index and offset bits
package dcache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMiss,
    StWriteback,
    StRefill,
    StRefillDone
  } state_e;

  function automatic int unsigned calc_offs_w(input int unsigned line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int unsigned calc_tag_w(input int unsigned addr_w,
                                             input int unsigned index_w,
                                             input int unsigned line_w);
    return addr_w - index_w - calc_offs_w(line_w);
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One way of the data cache: per-set valid, dirty, tag and line storage.
// Reads are combinational at index_i; a write (we_i) updates the addressed set
// at the next posedge and always marks it valid.
//   clk_i, rst_i      : clock, asynchronous active-low reset (clears valid/dirty)
//   index_i           : set index for both read and write
//   valid_o, dirty_o  : status of the addressed set
//   tag_o, line_o     : stored tag and line of the addressed set
//   we_i              : write strobe
//   wr_tag_i          : tag to store
//   wr_dirty_i        : dirty bit to store
//   wr_line_i         : line to store
import dcache_pkg::*;

module dcache_way #(
  parameter int unsigned INDEX_W = 5,
  parameter int unsigned TAG_W   = 22,
  parameter int unsigned LINE_W  = 256
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] index_i,
  output logic               valid_o,
  output logic               dirty_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic [LINE_W-1:0]  line_o,
  input  logic               we_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic               wr_dirty_i,
  input  logic [LINE_W-1:0]  wr_line_i
);

  localparam int unsigned SETS = 1 << INDEX_W;

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[index_i] <= 1'b1;
      dirty_q[index_i] <= wr_dirty_i;
    end
  end

  // Tag and data arrays carry no reset; valid gates their use.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[index_i]  <= wr_tag_i;
      data_q[index_i] <= wr_line_i;
    end
  end

  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign line_o  = data_q[index_i];

endmodule

// File: rtl/dcache_2way.sv
// 2-way set-associative, write-back, write-allocate data cache.
// Hits are served combinationally with no stall; misses run a
// MISS -> [WRITEBACK ->] REFILL -> REFILL_DONE sequence against a line-wide
// memory with a single-cycle ack, after which the access completes as a hit.
//   clk_i, rst_i               : clock, asynchronous active-low reset
//   p1_addr_i, p1_data_i       : CPU byte address (word aligned), store data
//   p1_MemRead_i, p1_MemWrite_i: access request (both set = write)
//   p1_data_o, p1_stall_o      : load data (0 when no hit), stall
//   mem_addr_o, mem_data_o     : line-aligned memory address, write-back line
//   mem_enable_o, mem_write_o  : memory request and direction
//   mem_data_i, mem_ack_i      : refill line, single-cycle completion
import dcache_pkg::*;

module dcache_2way #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INDEX_W = 5,
  parameter int unsigned LINE_W  = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [31:0]       p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int unsigned OFFS_W = calc_offs_w(LINE_W);
  localparam int unsigned TAG_W  = calc_tag_w(ADDR_W, INDEX_W, LINE_W);
  localparam int unsigned SETS   = 1 << INDEX_W;
  localparam int unsigned WSEL_W = OFFS_W - 2;

  // Address fields
  logic [INDEX_W-1:0] p1_index;
  logic [TAG_W-1:0]   p1_tag;
  logic [WSEL_W-1:0]  p1_wsel;
  logic               unused_addr;

  assign p1_index    = p1_addr_i[OFFS_W +: INDEX_W];
  assign p1_tag      = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign p1_wsel     = p1_addr_i[OFFS_W-1:2];
  assign unused_addr = ^p1_addr_i[1:0];

  // Way read/write signals
  logic              valid0, valid1, dirty0, dirty1;
  logic [TAG_W-1:0]  tag0, tag1;
  logic [LINE_W-1:0] line0, line1;
  logic              we0, we1;
  logic              wr_dirty0, wr_dirty1;
  logic [LINE_W-1:0] wr_line0, wr_line1;

  state_e            state_q;
  logic              victim_q;
  logic [SETS-1:0]   lru_q;
  logic              mem_enable_q, mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_data_q;

  logic              req, wr_req;
  logic              hit0, hit1, hit;
  logic [LINE_W-1:0] hit_line, merged_line;
  logic              victim_sel;
  logic              victim_valid, victim_dirty;
  logic [TAG_W-1:0]  victim_tag;
  logic [LINE_W-1:0] victim_line;
  logic              refill_we, refill0, refill1;

  assign req    = p1_MemRead_i | p1_MemWrite_i;
  assign wr_req = p1_MemWrite_i;

  assign hit0 = valid0 & (tag0 == p1_tag);
  assign hit1 = valid1 & (tag1 == p1_tag);
  assign hit  = hit0 | hit1;

  assign p1_stall_o = req & ~hit;

  assign hit_line  = hit1 ? line1 : line0;
  assign p1_data_o = hit ? hit_line[{p1_wsel, 5'b0} +: 32] : 32'h0;

  // Hit line with the selected word replaced by the store data
  always_comb begin
    merged_line = hit_line;
    merged_line[{p1_wsel, 5'b0} +: 32] = p1_data_i;
  end

  // First invalid way wins, way0 first; otherwise the LRU way
  always_comb begin
    if (!valid0) begin
      victim_sel = 1'b0;
    end else if (!valid1) begin
      victim_sel = 1'b1;
    end else begin
      victim_sel = lru_q[p1_index];
    end
  end

  assign victim_valid = victim_q ? valid1 : valid0;
  assign victim_dirty = victim_q ? dirty1 : dirty0;
  assign victim_tag   = victim_q ? tag1   : tag0;
  assign victim_line  = victim_q ? line1  : line0;

  // Refill write has priority over a store hit into the same way
  assign refill_we = (state_q == StRefill) & mem_ack_i;
  assign refill0   = refill_we & ~victim_q;
  assign refill1   = refill_we & victim_q;

  assign we0       = refill0 | (wr_req & hit0);
  assign we1       = refill1 | (wr_req & hit1);
  assign wr_dirty0 = ~refill0;
  assign wr_dirty1 = ~refill1;
  assign wr_line0  = refill0 ? mem_data_i : merged_line;
  assign wr_line1  = refill1 ? mem_data_i : merged_line;

  dcache_way #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .LINE_W  (LINE_W)
  ) u_way0 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .index_i    (p1_index),
    .valid_o    (valid0),
    .dirty_o    (dirty0),
    .tag_o      (tag0),
    .line_o     (line0),
    .we_i       (we0),
    .wr_tag_i   (p1_tag),
    .wr_dirty_i (wr_dirty0),
    .wr_line_i  (wr_line0)
  );

  dcache_way #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .LINE_W  (LINE_W)
  ) u_way1 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .index_i    (p1_index),
    .valid_o    (valid1),
    .dirty_o    (dirty1),
    .tag_o      (tag1),
    .line_o     (line1),
    .we_i       (we1),
    .wr_tag_i   (p1_tag),
    .wr_dirty_i (wr_dirty1),
    .wr_line_i  (wr_line1)
  );

  // LRU bit names the way to evict next: a hit points it at the other way
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lru_q <= '0;
    end else if (req && hit) begin
      lru_q[p1_index] <= hit0;
    end
  end

  // Controller with registered memory-side outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      victim_q     <= 1'b0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req && !hit) begin
            state_q  <= StMiss;
            victim_q <= victim_sel;
          end
        end
        StMiss: begin
          mem_enable_q <= 1'b1;
          if (victim_valid && victim_dirty) begin
            state_q     <= StWriteback;
            mem_write_q <= 1'b1;
            mem_addr_q  <= {victim_tag, p1_index, {OFFS_W{1'b0}}};
            mem_data_q  <= victim_line;
          end else begin
            state_q     <= StRefill;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {p1_tag, p1_index, {OFFS_W{1'b0}}};
          end
        end
        StWriteback: begin
          if (mem_ack_i) begin
            state_q     <= StRefill;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {p1_tag, p1_index, {OFFS_W{1'b0}}};
          end
        end
        StRefill: begin
          if (mem_ack_i) begin
            state_q      <= StRefillDone;
            mem_enable_q <= 1'b0;
          end
        end
        StRefillDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_dcache_2way.sv
// Self-checking bench for dcache_2way (default parameters: 32 sets, 256-bit lines).
// Reference model: per-set recency list of resident tags (capacity 2) with a
// dirty set, plus an architectural word view of memory.
module tb_dcache_2way;

  typedef struct {
    logic         w;
    logic [31:0]  a;
    logic [255:0] d;
  } txn_t;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  int tests_run    = 0;
  int tests_failed = 0;
  int lat          = 4;
  int stab_err     = 0;
  int align_err    = 0;

  txn_t         txn_q[$];
  logic [255:0] mem_lines [int unsigned];
  logic [31:0]  arch_m    [int unsigned];
  bit           dirty_m   [int unsigned];
  int unsigned  rec_q     [32][$];

  always #5 clk_i = ~clk_i;

  dcache_2way dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .p1_addr_i     (p1_addr_i),
    .p1_data_i     (p1_data_i),
    .p1_MemRead_i  (p1_MemRead_i),
    .p1_MemWrite_i (p1_MemWrite_i),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i)
  );

  function automatic logic [255:0] pat_line(input int unsigned la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = ((la + i * 4) * 32'h9E3779B9) ^ 32'h5A5A1234;
    return l;
  endfunction

  function automatic logic [255:0] mem_line(input int unsigned la);
    if (mem_lines.exists(la)) return mem_lines[la];
    return pat_line(la);
  endfunction

  function automatic logic [31:0] arch_word(input int unsigned a);
    logic [255:0] l;
    if (arch_m.exists(a)) return arch_m[a];
    l = mem_line(a & ~32'h1F);
    return l[((a >> 2) & 7) * 32 +: 32];
  endfunction

  function automatic logic [255:0] arch_line(input int unsigned la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = arch_word(la + i * 4);
    return l;
  endfunction

  // Memory responder: acks after lat cycles of enable, checks request stability
  initial begin : responder
    int cnt;
    logic         c_w;
    logic [31:0]  c_a;
    logic [255:0] c_d;
    txn_t t;
    cnt = 0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_i || !mem_enable_o) begin
        cnt = 0;
        mem_ack_i = 1'b0;
      end else begin
        if (cnt == 0) begin
          c_w = mem_write_o; c_a = mem_addr_o; c_d = mem_data_o;
          if (mem_addr_o[4:0] != 5'd0) align_err++;
        end else if (c_w !== mem_write_o || c_a !== mem_addr_o || (c_w && c_d !== mem_data_o)) begin
          stab_err++;
        end
        cnt++;
        if (cnt >= lat) begin
          mem_ack_i = 1'b1;
          t.w = mem_write_o; t.a = mem_addr_o;
          if (mem_write_o) begin
            mem_lines[mem_addr_o] = mem_data_o;
            t.d = mem_data_o;
          end else begin
            mem_data_i = mem_line(mem_addr_o);
            t.d = mem_data_i;
          end
          txn_q.push_back(t);
          cnt = 0;
        end else begin
          mem_ack_i = 1'b0;
        end
      end
    end
  end

  // Reference model step: predicts hit, optional writeback, load data
  task automatic model_step(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            output bit hit, output bit wb, output logic [31:0] wb_a,
                            output logic [255:0] wb_l, output logic [31:0] rdata);
    int unsigned set, tag, la, ev;
    int pos;
    set = (a >> 5) & 31; tag = a >> 10; la = a & ~32'h1F;
    hit = 0; wb = 0; wb_a = '0; wb_l = '0; pos = -1;
    for (int i = 0; i < rec_q[set].size(); i++) if (rec_q[set][i] == tag) pos = i;
    if (pos >= 0) begin
      hit = 1;
      rec_q[set].delete(pos);
    end else if (rec_q[set].size() == 2) begin
      ev = (rec_q[set].pop_front() << 10) | (set << 5);
      if (dirty_m.exists(ev)) begin
        wb = 1; wb_a = ev; wb_l = arch_line(ev);
        dirty_m.delete(ev);
      end
    end
    rec_q[set].push_back(tag);
    rdata = arch_word(a);
    if (wr) begin
      arch_m[a] = d;
      dirty_m[la] = 1;
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 32; s++) rec_q[s].delete();
    dirty_m.delete();
    arch_m.delete();
  endtask

  task automatic cpu_op(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] q, output int stalls);
    @(negedge clk_i);
    p1_addr_i = a; p1_data_i = d; p1_MemRead_i = rd; p1_MemWrite_i = wr;
    stalls = 0;
    #1;
    while (p1_stall_o && stalls < 200) begin
      @(negedge clk_i); #1;
      stalls++;
    end
    q = p1_data_o;
    @(posedge clk_i); #1;
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; p1_MemRead_i = 0; p1_MemWrite_i = 0; p1_addr_i = 32'h40; p1_data_i = 0;
    repeat (3) @(negedge clk_i);
    #1;
    tests_run++;
    if (mem_enable_o !== 1'b0) begin tests_failed++; $display("FAIL reset_enable got %b want 0", mem_enable_o); end
    tests_run++;
    if (mem_write_o !== 1'b0) begin tests_failed++; $display("FAIL reset_write got %b want 0", mem_write_o); end
    tests_run++;
    if (p1_stall_o !== 1'b0) begin tests_failed++; $display("FAIL reset_idle_stall got %b want 0", p1_stall_o); end
    p1_MemRead_i = 1'b1; #1;
    tests_run++;
    if (p1_stall_o !== 1'b1) begin tests_failed++; $display("FAIL reset_req_stall got %b want 1", p1_stall_o); end
    tests_run++;
    if (p1_data_o !== 32'h0) begin tests_failed++; $display("FAIL reset_nohit_data got %h want 0", p1_data_o); end
    p1_MemRead_i = 1'b0;
    @(negedge clk_i); rst_i = 1'b1;
    model_reset();
  endtask

  task automatic test_cold_read();
    logic [31:0] q, er, wa; logic [255:0] wl; bit h, wb; int st;
    txn_t t;
    lat = 4; txn_q.delete();
    model_step(0, 32'h40, 0, h, wb, wa, wl, er);
    cpu_op(1, 0, 32'h40, 0, q, st);
    tests_run++;
    if (st !== 6) begin tests_failed++; $display("FAIL cold_stall_cycles got %0d want 6", st); end
    tests_run++;
    if (q !== er) begin tests_failed++; $display("FAIL cold_data got %h want %h", q, er); end
    tests_run++;
    if (txn_q.size() != 1) begin tests_failed++; $display("FAIL cold_txn_count got %0d want 1", txn_q.size()); end
    else begin
      t = txn_q.pop_front();
      tests_run++;
      if ({t.w, t.a} !== {1'b0, 32'h40}) begin
        tests_failed++; $display("FAIL cold_refill got w=%b a=%h want w=0 a=00000040", t.w, t.a);
      end
    end
    tests_run++;
    if (dut.u_way0.valid_q[2] !== 1'b1 || dut.u_way1.valid_q[2] !== 1'b0) begin
      tests_failed++;
      $display("FAIL cold_way0_fill got v0=%b v1=%b want 1 0", dut.u_way0.valid_q[2], dut.u_way1.valid_q[2]);
    end
    tests_run++;
    if (mem_enable_o !== 1'b0) begin tests_failed++; $display("FAIL cold_enable_drop got %b want 0", mem_enable_o); end
  endtask

  task automatic test_write_hit();
    logic [31:0] q, er, wa; logic [255:0] wl; bit h, wb; int st;
    model_step(1, 32'h44, 32'hDEADBEEF, h, wb, wa, wl, er);
    cpu_op(0, 1, 32'h44, 32'hDEADBEEF, q, st);
    tests_run++;
    if (st !== 0) begin tests_failed++; $display("FAIL wrhit_stall got %0d want 0", st); end
    model_step(0, 32'h44, 0, h, wb, wa, wl, er);
    cpu_op(1, 0, 32'h44, 0, q, st);
    tests_run++;
    if (st !== 0) begin tests_failed++; $display("FAIL wrhit_read_stall got %0d want 0", st); end
    tests_run++;
    if (q !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL wrhit_read_data got %h want deadbeef", q); end
    tests_run++;
    if (dut.u_way0.dirty_q[2] !== 1'b1) begin
      tests_failed++; $display("FAIL wrhit_dirty got %b want 1", dut.u_way0.dirty_q[2]);
    end
  endtask

  task automatic test_second_way();
    logic [31:0] q, er, wa; logic [255:0] wl; bit h, wb; int st;
    txn_t t;
    lat = 4; txn_q.delete();
    model_step(0, 32'h440, 0, h, wb, wa, wl, er);
    cpu_op(1, 0, 32'h440, 0, q, st);
    tests_run++;
    if (st !== 6) begin tests_failed++; $display("FAIL way1_stall got %0d want 6", st); end
    tests_run++;
    if (q !== er) begin tests_failed++; $display("FAIL way1_data got %h want %h", q, er); end
    tests_run++;
    if (txn_q.size() != 1) begin tests_failed++; $display("FAIL way1_txn_count got %0d want 1", txn_q.size()); end
    else begin
      t = txn_q.pop_front();
      tests_run++;
      if ({t.w, t.a} !== {1'b0, 32'h440}) begin
        tests_failed++; $display("FAIL way1_refill got w=%b a=%h want w=0 a=00000440", t.w, t.a);
      end
    end
    tests_run++;
    if (dut.u_way1.valid_q[2] !== 1'b1) begin tests_failed++; $display("FAIL way1_valid got 0 want 1"); end
    model_step(0, 32'h40, 0, h, wb, wa, wl, er);
    cpu_op(1, 0, 32'h40, 0, q, st);
    tests_run++;
    if (st !== 0 || q !== er) begin
      tests_failed++; $display("FAIL way1_hit0 got stall=%0d data=%h want 0 %h", st, q, er);
    end
    tests_run++;
    if (dut.lru_q[2] !== 1'b1) begin tests_failed++; $display("FAIL lru_after_way0 got %b want 1", dut.lru_q[2]); end
    model_step(0, 32'h440, 0, h, wb, wa, wl, er);
    cpu_op(1, 0, 32'h440, 0, q, st);
    tests_run++;
    if (st !== 0 || q !== er) begin
      tests_failed++; $display("FAIL way1_hit1 got stall=%0d data=%h want 0 %h", st, q, er);
    end
    tests_run++;
    if (dut.lru_q[2] !== 1'b0) begin tests_failed++; $display("FAIL lru_after_way1 got %b want 0", dut.lru_q[2]); end
  endtask

  task automatic test_writeback();
    logic [31:0] q, er, wa; logic [255:0] wl; bit h, wb; int st;
    txn_t t;
    lat = 4; txn_q.delete();
    model_step(0, 32'h840, 0, h, wb, wa, wl, er);
    cpu_op(1, 0, 32'h840, 0, q, st);
    tests_run++;
    if (st !== 10) begin tests_failed++; $display("FAIL wb_stall got %0d want 10", st); end
    tests_run++;
    if (q !== er) begin tests_failed++; $display("FAIL wb_read_data got %h want %h", q, er); end
    tests_run++;
    if (txn_q.size() != 2) begin tests_failed++; $display("FAIL wb_txn_count got %0d want 2", txn_q.size()); end
    else begin
      t = txn_q.pop_front();
      tests_run++;
      if ({t.w, t.a} !== {1'b1, 32'h40}) begin
        tests_failed++; $display("FAIL wb_addr got w=%b a=%h want w=1 a=00000040", t.w, t.a);
      end
      tests_run++;
      if (t.d[63:32] !== 32'hDEADBEEF || t.d !== wl) begin
        tests_failed++; $display("FAIL wb_line got %h want %h", t.d, wl);
      end
      t = txn_q.pop_front();
      tests_run++;
      if ({t.w, t.a} !== {1'b0, 32'h840}) begin
        tests_failed++; $display("FAIL wb_refill got w=%b a=%h want w=0 a=00000840", t.w, t.a);
      end
    end
  endtask

  task automatic test_read_write_both();
    logic [31:0] q, er, wa; logic [255:0] wl; bit h, wb; int st;
    model_step(1, 32'h848, 32'h1234ABCD, h, wb, wa, wl, er);
    cpu_op(1, 1, 32'h848, 32'h1234ABCD, q, st);
    tests_run++;
    if (st !== 0) begin tests_failed++; $display("FAIL both_stall got %0d want 0", st); end
    model_step(0, 32'h848, 0, h, wb, wa, wl, er);
    cpu_op(1, 0, 32'h848, 0, q, st);
    tests_run++;
    if (q !== 32'h1234ABCD) begin tests_failed++; $display("FAIL both_data got %h want 1234abcd", q); end
    tests_run++;
    if (dut.u_way0.dirty_q[2] !== 1'b1) begin tests_failed++; $display("FAIL both_dirty got 0 want 1"); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] q, er, wa; logic [255:0] wl; bit h, wb; int st, n;
    lat = 8; txn_q.delete();
    @(negedge clk_i);
    p1_addr_i = 32'h1000; p1_MemRead_i = 1'b1; p1_MemWrite_i = 1'b0;
    n = 0;
    #1;
    while (!mem_enable_o && n < 50) begin @(negedge clk_i); #1; n++; end
    tests_run++;
    if (mem_enable_o !== 1'b1) begin tests_failed++; $display("FAIL abort_enable_seen got %b want 1", mem_enable_o); end
    #1 rst_i = 1'b0;
    #1;
    tests_run++;
    if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0) begin
      tests_failed++; $display("FAIL abort_enable_drop got en=%b wr=%b want 0 0", mem_enable_o, mem_write_o);
    end
    tests_run++;
    if (p1_stall_o !== 1'b1) begin tests_failed++; $display("FAIL abort_stall got %b want 1", p1_stall_o); end
    @(negedge clk_i);
    p1_MemRead_i = 1'b0; rst_i = 1'b1;
    model_reset();
    tests_run++;
    if (txn_q.size() != 0) begin tests_failed++; $display("FAIL abort_no_txn got %0d want 0", txn_q.size()); end
    lat = 4; txn_q.delete();
    model_step(0, 32'h40, 0, h, wb, wa, wl, er);
    cpu_op(1, 0, 32'h40, 0, q, st);
    tests_run++;
    if (st !== 6) begin tests_failed++; $display("FAIL abort_reread_stall got %0d want 6", st); end
    tests_run++;
    if (q !== er) begin tests_failed++; $display("FAIL abort_reread_data got %h want %h", q, er); end
    txn_q.delete();
  endtask

  task automatic test_random();
    logic [31:0] q, er, wa, a, d; logic [255:0] wl; bit h, wb; int st, kind, nexp;
    logic rd, wr;
    txn_t t;
    for (int i = 0; i < 300; i++) begin
      a = (($urandom % 5) << 10) | (($urandom % 4) << 5) | (($urandom % 8) << 2);
      d = $urandom;
      kind = $urandom % 3;
      rd = (kind != 1); wr = (kind != 0);
      lat = 1 + $urandom % 5;
      txn_q.delete();
      model_step(wr, a, d, h, wb, wa, wl, er);
      cpu_op(rd, wr, a, d, q, st);
      tests_run++;
      if ((st == 0) !== h) begin
        tests_failed++; $display("FAIL rnd_hit op%0d a=%h got stalls=%0d want hit=%b", i, a, st, h);
      end
      if (!wr) begin
        tests_run++;
        if (q !== er) begin tests_failed++; $display("FAIL rnd_load op%0d a=%h got %h want %h", i, a, q, er); end
      end
      nexp = h ? 0 : (wb ? 2 : 1);
      tests_run++;
      if (txn_q.size() != nexp) begin
        tests_failed++; $display("FAIL rnd_txn_count op%0d got %0d want %0d", i, txn_q.size(), nexp);
      end else if (nexp > 0) begin
        if (wb) begin
          t = txn_q.pop_front();
          tests_run++;
          if ({t.w, t.a, t.d} !== {1'b1, wa, wl}) begin
            tests_failed++; $display("FAIL rnd_wb op%0d got w=%b a=%h want a=%h", i, t.w, t.a, wa);
          end
        end
        t = txn_q.pop_front();
        tests_run++;
        if ({t.w, t.a} !== {1'b0, a & ~32'h1F}) begin
          tests_failed++; $display("FAIL rnd_refill op%0d got w=%b a=%h want %h", i, t.w, t.a, a & ~32'h1F);
        end
      end
    end
    tests_run++;
    if (stab_err != 0 || align_err != 0) begin
      tests_failed++; $display("FAIL mem_stability got stab=%0d align=%0d want 0 0", stab_err, align_err);
    end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_write_hit();
    test_second_way();
    test_writeback();
    test_read_write_both();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
